// File: rtl/cbx_io_ccff_pkg.sv
// Shared constants and sizing helper for the CB/IO config-chain bank.
package cbx_io_ccff_pkg;

    localparam logic DIR_INPUT = 1'b1;

    function automatic int total_bits(input int cb, input int nio, input int w);
        return cb + nio * w;
    endfunction

endpackage

// File: rtl/ccff_shadow_chain.sv
// Shadow shift register for the config chain plus its load counter and overrun flag.
module ccff_shadow_chain #(
    parameter int TOTAL = 12
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_head,
    input  logic                       i_shift_en,
    input  logic                       i_clr,
    output logic                       o_tail,
    output logic [TOTAL-1:0]           o_shadow,
    output logic [$clog2(TOTAL+1)-1:0] o_cnt,
    output logic                       o_loaded,
    output logic                       o_overrun
);

    localparam int CNT_W = $clog2(TOTAL+1);

    logic [TOTAL-1:0] r_shadow;
    logic [CNT_W-1:0] r_cnt;
    logic             r_overrun;
    logic             w_loaded;

    assign w_loaded = (r_cnt == CNT_W'(TOTAL));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_shadow  <= '0;
            r_cnt     <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (i_shift_en) begin
                r_shadow <= {r_shadow[TOTAL-2:0], i_head};
                if (!w_loaded)
                    r_cnt <= r_cnt + CNT_W'(1);
                // Extra bits past a full load still shift through; only flag them.
                if (w_loaded)
                    r_overrun <= 1'b1;
            end
            if (i_clr) begin
                r_cnt     <= '0;
                r_overrun <= 1'b0;
            end
        end
    end

    assign o_tail    = r_shadow[TOTAL-1];
    assign o_shadow  = r_shadow;
    assign o_cnt     = r_cnt;
    assign o_loaded  = w_loaded;
    assign o_overrun = r_overrun;

endmodule

// File: rtl/cbx_io_ccff_bank.sv
// Double-buffered config bank for an edge tile: shadow chain, apply/commit logic,
// and isolation-aware pad direction register.
module cbx_io_ccff_bank
    import cbx_io_ccff_pkg::*;
#(
    parameter  int CB_BITS     = 96,
    parameter  int NUM_IO      = 4,
    parameter  int IO_CFG_BITS = 1,
    localparam int TOTAL       = total_bits(CB_BITS, NUM_IO, IO_CFG_BITS),
    localparam int CNT_W       = $clog2(TOTAL+1)
) (
    input  logic                          prog_clk,
    input  logic                          pReset,
    input  logic                          ccff_head,
    input  logic                          ccff_shift_en,
    input  logic                          ccff_apply,
    input  logic                          IO_ISOL_N,
    output logic                          ccff_tail,
    output logic [CB_BITS-1:0]            cb_cfg,
    output logic [NUM_IO*IO_CFG_BITS-1:0] io_cfg,
    output logic [NUM_IO-1:0]             gfpga_pad_EMBEDDED_IO_HD_SOC_DIR,
    output logic [CNT_W-1:0]              cfg_cnt,
    output logic                          cfg_loaded,
    output logic                          cfg_valid,
    output logic                          cfg_overrun,
    output logic                          apply_rej
);

    logic [TOTAL-1:0]  w_shadow;
    logic              w_loaded;
    logic              w_accept;
    logic [TOTAL-1:0]  r_active;
    logic              r_valid;
    logic              r_rej;
    logic [NUM_IO-1:0] r_dir;

    // A shift in the same cycle would change the shadow under the commit, so refuse it.
    assign w_accept = ccff_apply & w_loaded & ~ccff_shift_en;

    ccff_shadow_chain #(.TOTAL(TOTAL)) u_chain (
        .i_clk      (prog_clk),
        .i_rst      (pReset),
        .i_head     (ccff_head),
        .i_shift_en (ccff_shift_en),
        .i_clr      (w_accept),
        .o_tail     (ccff_tail),
        .o_shadow   (w_shadow),
        .o_cnt      (cfg_cnt),
        .o_loaded   (w_loaded),
        .o_overrun  (cfg_overrun)
    );

    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            r_active <= '0;
            r_valid  <= 1'b0;
            r_rej    <= 1'b0;
            r_dir    <= {NUM_IO{DIR_INPUT}};
        end else begin
            if (w_accept) begin
                r_active <= w_shadow;
                r_valid  <= 1'b1;
            end
            r_rej <= ccff_apply & ~w_accept;
            for (int i = 0; i < NUM_IO; i++)
                r_dir[i] <= (IO_ISOL_N & r_valid) ? r_active[CB_BITS + i*IO_CFG_BITS] : DIR_INPUT;
        end
    end

    assign cb_cfg                           = r_active[CB_BITS-1:0];
    assign io_cfg                           = r_active[TOTAL-1:CB_BITS];
    assign gfpga_pad_EMBEDDED_IO_HD_SOC_DIR = r_dir;
    assign cfg_loaded                       = w_loaded;
    assign cfg_valid                        = r_valid;
    assign apply_rej                        = r_rej;

endmodule

// File: tb/tb_cbx_io_ccff_bank.sv
// Self-checking bench for cbx_io_ccff_bank (CB_BITS=8, NUM_IO=4, IO_CFG_BITS=1).
module tb_cbx_io_ccff_bank;

    localparam int CB  = 8;
    localparam int NIO = 4;
    localparam int TOT = 12;

    logic       prog_clk = 1'b0;
    logic       pReset = 1'b1;
    logic       ccff_head = 1'b0;
    logic       ccff_shift_en = 1'b0;
    logic       ccff_apply = 1'b0;
    logic       IO_ISOL_N = 1'b1;
    logic       ccff_tail;
    logic [7:0] cb_cfg;
    logic [3:0] io_cfg;
    logic [3:0] dir;
    logic [3:0] cfg_cnt;
    logic       cfg_loaded, cfg_valid, cfg_overrun, apply_rej;

    int total = 0;
    int bad   = 0;

    cbx_io_ccff_bank #(.CB_BITS(CB), .NUM_IO(NIO), .IO_CFG_BITS(1)) dut (
        .prog_clk                         (prog_clk),
        .pReset                           (pReset),
        .ccff_head                        (ccff_head),
        .ccff_shift_en                    (ccff_shift_en),
        .ccff_apply                       (ccff_apply),
        .IO_ISOL_N                        (IO_ISOL_N),
        .ccff_tail                        (ccff_tail),
        .cb_cfg                           (cb_cfg),
        .io_cfg                           (io_cfg),
        .gfpga_pad_EMBEDDED_IO_HD_SOC_DIR (dir),
        .cfg_cnt                          (cfg_cnt),
        .cfg_loaded                       (cfg_loaded),
        .cfg_valid                        (cfg_valid),
        .cfg_overrun                      (cfg_overrun),
        .apply_rej                        (apply_rej)
    );

    always #5 prog_clk = ~prog_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, let the edge happen, sample 1 time unit later.
    task automatic step(input logic rst, input logic sh, input logic hd,
                        input logic ap, input logic iso);
        pReset = rst; ccff_shift_en = sh; ccff_head = hd; ccff_apply = ap; IO_ISOL_N = iso;
        @(posedge prog_clk);
        #1;
    endtask

    typedef struct {
        logic       sh, hd, ap, iso;
        logic [7:0] cb;
        logic [3:0] io, dr, cnt;
        logic       vld, rej, ovr, tail;
    } vec_t;

    vec_t tbl[18];

    // Behavioural reference: the shadow is a TOTAL-bit number that gets doubled plus the new bit.
    int m_sh, m_act, m_cnt, m_dir;
    bit m_valid, m_ovr, m_rej;

    task automatic model(input bit rst, input bit sh, input bit hd, input bit ap, input bit iso);
        bit full, acc;
        if (rst) begin
            m_sh = 0; m_act = 0; m_cnt = 0; m_dir = 15;
            m_valid = 0; m_ovr = 0; m_rej = 0;
            return;
        end
        full  = (m_cnt == TOT);
        acc   = ap && full && !sh;
        m_dir = (iso && m_valid) ? (m_act >> CB) % 16 : 15;
        m_rej = ap && !acc;
        if (sh) begin
            if (full) m_ovr = 1;
            m_sh  = (m_sh * 2 + int'(hd)) % (1 << TOT);
            m_cnt = (m_cnt < TOT) ? m_cnt + 1 : TOT;
        end
        if (acc) begin
            m_act = m_sh; m_valid = 1; m_cnt = 0; m_ovr = 0;
        end
    endtask

    initial begin
        logic [11:0] pat;
        bit r, s, h, a, i;

        // ---- reset and idle ----
        step(1, 0, 0, 0, 1);
        step(1, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        chk("rst_cb",   cb_cfg, 8'h00);
        chk("rst_io",   io_cfg, 4'h0);
        chk("rst_dir",  dir, 4'hF);
        chk("rst_cnt",  cfg_cnt, 4'd0);
        chk("rst_tail", ccff_tail, 1'b0);
        chk("rst_vld",  cfg_valid, 1'b0);
        chk("rst_ovr",  cfg_overrun, 1'b0);
        chk("rst_rej",  apply_rej, 1'b0);

        // ---- table: load 0xA5C MSB first, apply, isolation toggle, early apply ----
        pat = 12'hA5C;
        for (int k = 0; k < 12; k++)
            tbl[k] = '{sh:1, hd:pat[11-k], ap:0, iso:1, cb:8'h00, io:4'h0, dr:4'hF,
                       cnt:4'(k+1), vld:0, rej:0, ovr:0, tail:(k == 11)};
        tbl[12] = '{sh:0, hd:0, ap:1, iso:1, cb:8'h5C, io:4'hA, dr:4'hF, cnt:0, vld:1, rej:0, ovr:0, tail:1};
        tbl[13] = '{sh:0, hd:0, ap:0, iso:1, cb:8'h5C, io:4'hA, dr:4'hA, cnt:0, vld:1, rej:0, ovr:0, tail:1};
        tbl[14] = '{sh:0, hd:0, ap:0, iso:0, cb:8'h5C, io:4'hA, dr:4'hF, cnt:0, vld:1, rej:0, ovr:0, tail:1};
        tbl[15] = '{sh:0, hd:0, ap:0, iso:1, cb:8'h5C, io:4'hA, dr:4'hA, cnt:0, vld:1, rej:0, ovr:0, tail:1};
        tbl[16] = '{sh:0, hd:0, ap:1, iso:1, cb:8'h5C, io:4'hA, dr:4'hA, cnt:0, vld:1, rej:1, ovr:0, tail:1};
        tbl[17] = '{sh:0, hd:0, ap:0, iso:1, cb:8'h5C, io:4'hA, dr:4'hA, cnt:0, vld:1, rej:0, ovr:0, tail:1};
        for (int k = 0; k < 18; k++) begin
            step(0, tbl[k].sh, tbl[k].hd, tbl[k].ap, tbl[k].iso);
            chk($sformatf("tbl%0d_cb", k),   cb_cfg, tbl[k].cb);
            chk($sformatf("tbl%0d_io", k),   io_cfg, tbl[k].io);
            chk($sformatf("tbl%0d_dir", k),  dir, tbl[k].dr);
            chk($sformatf("tbl%0d_cnt", k),  cfg_cnt, tbl[k].cnt);
            chk($sformatf("tbl%0d_vld", k),  cfg_valid, tbl[k].vld);
            chk($sformatf("tbl%0d_rej", k),  apply_rej, tbl[k].rej);
            chk($sformatf("tbl%0d_ovr", k),  cfg_overrun, tbl[k].ovr);
            chk($sformatf("tbl%0d_tail", k), ccff_tail, tbl[k].tail);
        end

        // ---- apply after 11 shifts is rejected ----
        for (int k = 0; k < 11; k++) step(0, 1, 1, 0, 1);
        chk("p11_cnt", cfg_cnt, 4'd11);
        chk("p11_loaded", cfg_loaded, 1'b0);
        step(0, 0, 0, 1, 1);
        chk("p11_rej", apply_rej, 1'b1);
        chk("p11_cb", cb_cfg, 8'h5C);
        step(0, 0, 0, 0, 1);
        chk("p11_rej_clr", apply_rej, 1'b0);
        step(0, 1, 1, 0, 1);
        chk("p12_cnt", cfg_cnt, 4'd12);
        chk("p12_loaded", cfg_loaded, 1'b1);
        // apply together with a shift at full count: rejected, overrun, count holds
        step(0, 1, 1, 1, 1);
        chk("ps_rej", apply_rej, 1'b1);
        chk("ps_ovr", cfg_overrun, 1'b1);
        chk("ps_cnt", cfg_cnt, 4'd12);
        chk("ps_cb", cb_cfg, 8'h5C);
        step(0, 0, 0, 1, 1);
        chk("pa_cb", cb_cfg, 8'hFF);
        chk("pa_io", io_cfg, 4'hF);
        chk("pa_ovr", cfg_overrun, 1'b0);
        chk("pa_cnt", cfg_cnt, 4'd0);

        // ---- reset mid-shift and mid-apply, then a fresh load ----
        for (int k = 0; k < 6; k++) step(0, 1, 1, 0, 1);
        step(1, 1, 1, 1, 1);
        chk("mr_cnt", cfg_cnt, 4'd0);
        chk("mr_vld", cfg_valid, 1'b0);
        chk("mr_cb", cb_cfg, 8'h00);
        chk("mr_dir", dir, 4'hF);
        chk("mr_tail", ccff_tail, 1'b0);
        pat = 12'h3C9;
        for (int k = 0; k < 12; k++) step(0, 1, pat[11-k], 0, 1);
        chk("fl_tail", ccff_tail, 1'b0);
        step(0, 0, 0, 1, 1);
        chk("fl_cb", cb_cfg, 8'hC9);
        chk("fl_io", io_cfg, 4'h3);
        chk("fl_vld", cfg_valid, 1'b1);
        step(0, 0, 0, 0, 1);
        chk("fl_dir", dir, 4'h3);

        // ---- randomized run against the reference model ----
        step(1, 0, 0, 0, 1);
        model(1, 0, 0, 0, 1);
        for (int n = 0; n < 1500; n++) begin
            r = ($urandom_range(0, 199) == 0);
            s = ($urandom_range(0, 9) < 8);
            h = 1'($urandom);
            a = ($urandom_range(0, 9) < 2);
            i = ($urandom_range(0, 9) < 8);
            step(r, s, h, a, i);
            model(r, s, h, a, i);
            chk("rnd_cb",   cb_cfg, 32'(m_act % 256));
            chk("rnd_io",   io_cfg, 32'((m_act >> CB) % 16));
            chk("rnd_dir",  dir, 32'(m_dir));
            chk("rnd_cnt",  cfg_cnt, 32'(m_cnt));
            chk("rnd_ld",   cfg_loaded, 32'(m_cnt == TOT));
            chk("rnd_vld",  cfg_valid, 32'(m_valid));
            chk("rnd_ovr",  cfg_overrun, 32'(m_ovr));
            chk("rnd_rej",  apply_rej, 32'(m_rej));
            chk("rnd_tail", ccff_tail, 32'((m_sh >> (TOT-1)) % 2));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
